router_ctrl: RTL
================

ROUTER_CTRL -- requirements
Module: router_ctrl

Interface
REQ-001 SHALL have parameters: ROUTER_COUNT, default 4, number of row routers sequenced; ADDR_WIDTH, default 8, SRAM word address width.
REQ-002 SHALL have ports: i_clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have i_rst  in  1  synchronous active-high reset.
REQ-004 SHALL have i_start  in  1  job request pulse; i_abort  in  1  cancel current job.
REQ-005 SHALL have i_sram_base  in  ADDR_WIDTH  first tile word address; i_sram_count  in  ADDR_WIDTH+1  words to read (0..2^ADDR_WIDTH).
REQ-006 SHALL have i_addr_empty  in  1  all row MPPs drained (AND of rows); i_data_empty  in  1  all row MISOs drained.
REQ-007 SHALL have o_reg_clear, o_ag_en, o_ac_en, o_miso_pop_en  out  1 each  router/generator controls.
REQ-008 SHALL have o_ag_valid_row  out  ROUTER_COUNT  row ID aligned to generator valid; o_row_valid  out  1  qualifies it.
REQ-009 SHALL have o_sram_rd_en  out  1, o_sram_addr  out  ADDR_WIDTH  SRAM read port; o_data_addr  out  ADDR_WIDTH, o_data_valid  out  1  address/valid aligned with SRAM read data.
REQ-010 SHALL have o_busy, o_done (1-cycle pulse), o_error (sticky until next accepted start)  out  1 each.

Function
REQ-011 SHALL implement FSM states IDLE, CLEAR, ADDR_GEN, AG_WAIT, FETCH, FETCH_WAIT, DRAIN, DONE.
REQ-012 IDLE: i_start=1 latches base/count, clears o_error, goes to CLEAR next cycle; i_start in any other state SHALL be ignored.
REQ-013 CLEAR: o_reg_clear=1 for exactly one cycle -> ADDR_GEN.
REQ-014 ADDR_GEN: o_ag_en=1 for exactly ROUTER_COUNT cycles, internal row counter 0..ROUTER_COUNT-1 -> AG_WAIT.
REQ-015 Row r issued at cycle k SHALL appear on o_ag_valid_row with o_row_valid=1 at cycle k+1 (generator latency 1); AG_WAIT covers the last row -> FETCH.
REQ-016 FETCH: o_ac_en=1; one read per cycle, o_sram_addr = base, base+1, ... for count cycles, address wrapping modulo 2^ADDR_WIDTH; then FETCH_WAIT.
REQ-017 o_data_valid/o_data_addr SHALL equal o_sram_rd_en/o_sram_addr delayed one cycle; o_ac_en SHALL stay 1 through FETCH_WAIT.
REQ-018 FETCH: if i_addr_empty=1 before count exhausted, SHALL stop issuing reads next cycle -> FETCH_WAIT (early exit).
REQ-019 FETCH_WAIT (one cycle, last data valid): i_addr_empty=1 -> DRAIN; else set o_error -> DRAIN.
REQ-020 count=0: FETCH SHALL issue no reads and go directly to FETCH_WAIT.
REQ-021 DRAIN: o_miso_pop_en=1 every cycle until i_data_empty=1 sampled, minimum ROUTER_COUNT cycles (stagger of row pops) -> DONE.
REQ-022 DONE: o_done=1 one cycle -> IDLE; o_busy=1 in all states except IDLE.
REQ-023 i_abort=1 in any non-IDLE state SHALL go to CLEAR next cycle without o_done, then IDLE; abort beats all other transitions, ignored in IDLE.
REQ-024 All outputs SHALL be registered; control outputs 0 outside their named states.

Reset
REQ-025 i_rst=1 SHALL force IDLE, all outputs 0, counters 0, latched base/count 0, regardless of state, including mid-FETCH/DRAIN.
REQ-026 First cycle after reset release SHALL accept i_start.

Structure
REQ-027 FSM state enum and default parameter values SHALL live in shared package router_pkg.
REQ-028 Single sub-module SHALL be rd_addr_seq (base/count read address counter with 1-cycle valid/addr delay); remainder flat.

Verification
REQ-029 RC=4, base=0x10, count=5, i_addr_empty rises after last data: reg_clear 1 cycle, ag_en 4 cycles, rows 0..3 on o_ag_valid_row, reads 0x10..0x14, data_valid 1 cycle late, DRAIN, o_done once, o_error=0.
REQ-030 base=0xFE, count=4: o_sram_addr 0xFE,0xFF,0x00,0x01.
REQ-031 count=9, i_addr_empty=1 after 3rd read: exactly 3 reads, no further rd_en, o_error=0.
REQ-032 count=2, i_addr_empty stays 0: o_error=1 after FETCH_WAIT, DRAIN and o_done still occur; o_error clears on next start.
REQ-033 i_abort during DRAIN: CLEAR pulse next cycle, IDLE, no o_done; i_start during busy ignored.
REQ-034 i_rst mid-FETCH: next cycle all outputs 0, IDLE; new start completes normally.

Source files
------------

// File: rtl/router_pkg.sv
// Shared state encoding and default sizing for the row-router job controller.
package router_pkg;

    localparam int unsigned DEF_ROUTER_COUNT = 4;
    localparam int unsigned DEF_ADDR_WIDTH   = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ADDR_GEN,
        AG_WAIT,
        FETCH,
        FETCH_WAIT,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/rd_addr_seq.sv
// SRAM read address sequencer: walks base..base+count-1 (modulo 2^ADDR_WIDTH) one word
// per issue and re-times strobe/address by one cycle to line up with returned data.
module rd_addr_seq
    import router_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [ADDR_WIDTH:0]   count_i,
    input  logic                  issue_i,
    output logic                  left_zero_o,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  data_valid_o,
    output logic [ADDR_WIDTH-1:0] data_addr_o
);

    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [ADDR_WIDTH:0]   left_q, left_d;
    logic                  rd_en_q, data_valid_q;
    logic [ADDR_WIDTH-1:0] addr_q, data_addr_q;
    logic                  issue;

    assign issue = issue_i && (left_q != '0);

    // NOTE: every variable gets its default before any branch so no path can infer a latch.
    always_comb begin
        next_addr_d = next_addr_q;
        left_d      = left_q;
        if (load_i) begin
            next_addr_d = base_i;
            left_d      = count_i;
        end else if (issue) begin
            next_addr_d = next_addr_q + ADDR_WIDTH'(1);
            left_d      = left_q - (ADDR_WIDTH + 1)'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            next_addr_q  <= '0;
            left_q       <= '0;
            rd_en_q      <= 1'b0;
            addr_q       <= '0;
            data_valid_q <= 1'b0;
            data_addr_q  <= '0;
        end else begin
            next_addr_q  <= next_addr_d;
            left_q       <= left_d;
            rd_en_q      <= issue;
            addr_q       <= issue ? next_addr_q : '0;
            data_valid_q <= rd_en_q;
            data_addr_q  <= addr_q;
        end
    end

    assign left_zero_o  = (left_q == '0);
    assign rd_en_o      = rd_en_q;
    assign addr_o       = addr_q;
    assign data_valid_o = data_valid_q;
    assign data_addr_o  = data_addr_q;

endmodule

// File: rtl/router_ctrl.sv
// Row-router job controller: clears the routers, steps the address generator over every
// row, streams the tile out of SRAM, then drains the row MISOs before reporting done.
module router_ctrl
    import router_pkg::*;
#(
    parameter int unsigned ROUTER_COUNT = DEF_ROUTER_COUNT,
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic [ADDR_WIDTH-1:0]   i_sram_base,
    input  logic [ADDR_WIDTH:0]     i_sram_count,
    input  logic                    i_addr_empty,
    input  logic                    i_data_empty,
    output logic                    o_reg_clear,
    output logic                    o_ag_en,
    output logic                    o_ac_en,
    output logic                    o_miso_pop_en,
    output logic [ROUTER_COUNT-1:0] o_ag_valid_row,
    output logic                    o_row_valid,
    output logic                    o_sram_rd_en,
    output logic [ADDR_WIDTH-1:0]   o_sram_addr,
    output logic [ADDR_WIDTH-1:0]   o_data_addr,
    output logic                    o_data_valid,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_error
);

    localparam int unsigned      CNT_W   = (ROUTER_COUNT > 1) ? $clog2(ROUTER_COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ROUTER_COUNT - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    abort_q, abort_d;
    logic                    error_q, error_d;
    logic                    reg_clear_q, ag_en_q, ac_en_q, pop_q, busy_q, done_q;
    logic                    row_valid_q, row_live;
    logic [ROUTER_COUNT-1:0] row_q;
    logic                    load, issue, left_zero;

    always_comb begin
        state_d = state_q;
        abort_d = abort_q;
        error_d = error_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = CLEAR;
                    abort_d = 1'b0;
                    error_d = 1'b0;
                    load    = 1'b1;
                end
            end
            CLEAR:      state_d = abort_q ? IDLE : ADDR_GEN;
            ADDR_GEN:   if (cnt_q == CNT_MAX) state_d = AG_WAIT;
            AG_WAIT:    state_d = FETCH;
            FETCH:      if (left_zero || i_addr_empty) state_d = FETCH_WAIT;
            FETCH_WAIT: begin
                state_d = DRAIN;
                if (!i_addr_empty) error_d = 1'b1;
            end
            DRAIN:      if ((cnt_q == CNT_MAX) && i_data_empty) state_d = DONE;
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase

        // Abort wins over every other transition; the CLEAR it enters then falls back to IDLE.
        if (i_abort && (state_q != IDLE)) begin
            state_d = CLEAR;
            abort_d = 1'b1;
            error_d = error_q;
        end

        // One counter serves as row index in ADDR_GEN and as minimum-drain timer in DRAIN.
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (((state_q == ADDR_GEN) || (state_q == DRAIN)) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        issue    = (state_d == FETCH);
        row_live = ag_en_q && ((state_d == ADDR_GEN) || (state_d == AG_WAIT));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            abort_q     <= 1'b0;
            error_q     <= 1'b0;
            reg_clear_q <= 1'b0;
            ag_en_q     <= 1'b0;
            ac_en_q     <= 1'b0;
            pop_q       <= 1'b0;
            row_valid_q <= 1'b0;
            row_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            abort_q     <= abort_d;
            error_q     <= error_d;
            reg_clear_q <= (state_d == CLEAR);
            ag_en_q     <= (state_d == ADDR_GEN);
            ac_en_q     <= (state_d == FETCH) || (state_d == FETCH_WAIT);
            pop_q       <= (state_d == DRAIN);
            row_valid_q <= row_live;
            row_q       <= row_live ? (ROUTER_COUNT'(1) << cnt_q) : '0;
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
        end
    end

    rd_addr_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rd_addr_seq (
        .clk_i        (i_clk),
        .rst_i        (i_rst),
        .load_i       (load),
        .base_i       (i_sram_base),
        .count_i      (i_sram_count),
        .issue_i      (issue),
        .left_zero_o  (left_zero),
        .rd_en_o      (o_sram_rd_en),
        .addr_o       (o_sram_addr),
        .data_valid_o (o_data_valid),
        .data_addr_o  (o_data_addr)
    );

    assign o_reg_clear    = reg_clear_q;
    assign o_ag_en        = ag_en_q;
    assign o_ac_en        = ac_en_q;
    assign o_miso_pop_en  = pop_q;
    assign o_ag_valid_row = row_q;
    assign o_row_valid    = row_valid_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_error        = error_q;

endmodule
